// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and sizing helper for the matmul engine.
package matmul_pkg;

   localparam logic [4:0] OP_A = 5'b00100;
   localparam logic [4:0] OP_B = 5'b01000;
   localparam logic [4:0] OP_C = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      LOAD_C,
      CALC,
      WRITE,
      DONE
   } state_e;

   function automatic int calc_max_dim(input int bus_w, input int data_w);
      return bus_w / data_w;
   endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Signed DATA_WIDTH x DATA_WIDTH multiply into a wrapping BUS_WIDTH accumulator
// with optional bias preload and per-step signed overflow detection.
module matmul_mac_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [BUS_WIDTH-1:0]  bias_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [BUS_WIDTH-1:0]  acc_o,
   output logic                  ovf_o
);
   localparam int EXT = BUS_WIDTH - DATA_WIDTH;

   logic [BUS_WIDTH-1:0] a_ext, b_ext, prod, base, sum, acc_d, acc_q;

   // Low BUS_WIDTH bits of the product of sign-extended operands equal the signed product.
   always_comb begin
      a_ext = {{EXT{a_i[DATA_WIDTH-1]}}, a_i};
      b_ext = {{EXT{b_i[DATA_WIDTH-1]}}, b_i};
      prod  = a_ext * b_ext;
      base  = load_i ? bias_i : acc_q;
      sum   = base + prod;
      ovf_o = en_i & (base[BUS_WIDTH-1] == prod[BUS_WIDTH-1])
                   & (sum[BUS_WIDTH-1] != base[BUS_WIDTH-1]);
      acc_d = en_i ? sum : acc_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/matmul_seq_engine.sv
// Sequential matrix-multiply engine: loads A, B (and bias C when MATMUL_BIAS_EN
// is defined), accumulates one term per cycle and streams C' to the scratchpad.
module matmul_seq_engine
   import matmul_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int BUS_WIDTH  = 16,
   parameter  int ADDR_WIDTH = 32,
   localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int DIM_W      = $clog2(MAX_DIM) + 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic                       mode_i,
   input  logic [DIM_W-1:0]           n_dim_i,
   input  logic [DIM_W-1:0]           k_dim_i,
   input  logic [DIM_W-1:0]           m_dim_i,
   output logic                       rd_req_o,
   output logic [ADDR_WIDTH-1:0]      rd_addr_o,
   input  logic [BUS_WIDTH-1:0]       rd_data_i,
   input  logic                       rd_valid_i,
   output logic                       wr_en_o,
   output logic [ADDR_WIDTH-1:0]      wr_addr_o,
   output logic [BUS_WIDTH-1:0]       wr_data_o,
   input  logic                       wr_ready_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic [MAX_DIM*MAX_DIM-1:0] flags_o
);
   localparam int IW    = $clog2(MAX_DIM);
   localparam int IDX_W = 2 * IW;
   localparam int NE    = MAX_DIM * MAX_DIM;

   typedef logic [MAX_DIM-1:0][DATA_WIDTH-1:0] row_t;

   state_e                state_q, state_d;
   logic [IW-1:0]         row_q, row_d, col_q, col_d, idx_q, idx_d;
   logic [DIM_W-1:0]      n_q, n_d, k_q, k_d, m_q, m_d;
   logic                  err_q, err_d;
   logic [NE-1:0]         flags_q, flags_d;
   row_t [MAX_DIM-1:0]    a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]      elem;
   logic                  last_row_n, last_row_k, last_col, last_idx, illegal;
   logic                  mac_en, mac_load, mac_ovf;
   logic [BUS_WIDTH-1:0]  mac_bias, mac_acc;

`ifdef MATMUL_BIAS_EN
   logic                       bias_q, bias_d;
   logic [NE-1:0][BUS_WIDTH-1:0] c_q, c_d;
   assign mac_bias = bias_q ? c_q[elem] : '0;
`else
   logic unused_mode;
   assign unused_mode = mode_i;
   assign mac_bias    = '0;
`endif

   assign elem       = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);
   assign last_row_n = ({1'b0, row_q} == n_q - DIM_W'(1));
   assign last_row_k = ({1'b0, row_q} == k_q - DIM_W'(1));
   assign last_col   = ({1'b0, col_q} == m_q - DIM_W'(1));
   assign last_idx   = ({1'b0, idx_q} == k_q - DIM_W'(1));
   assign illegal    = (n_dim_i == '0) || (n_dim_i > DIM_W'(MAX_DIM)) ||
                       (k_dim_i == '0) || (k_dim_i > DIM_W'(MAX_DIM)) ||
                       (m_dim_i == '0) || (m_dim_i > DIM_W'(MAX_DIM));

   matmul_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_mac (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (mac_en),
      .load_i (mac_load),
      .bias_i (mac_bias),
      .a_i    (a_q[row_q][idx_q]),
      .b_i    (b_q[idx_q][col_q]),
      .acc_o  (mac_acc),
      .ovf_o  (mac_ovf)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      idx_d   = idx_q;
      n_d     = n_q;
      k_d     = k_q;
      m_d     = m_q;
      err_d   = err_q;
      flags_d = flags_q;
      a_d     = a_q;
      b_d     = b_q;
`ifdef MATMUL_BIAS_EN
      bias_d  = bias_q;
      c_d     = c_q;
`endif
      rd_req_o  = 1'b0;
      rd_addr_o = '0;
      wr_en_o   = 1'b0;
      wr_addr_o = '0;
      wr_data_o = '0;
      mac_en    = 1'b0;
      mac_load  = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            n_d     = n_dim_i;
            k_d     = k_dim_i;
            m_d     = m_dim_i;
            err_d   = illegal;
            flags_d = '0;
            a_d     = '0;
            b_d     = '0;
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
`ifdef MATMUL_BIAS_EN
            bias_d  = mode_i;
`endif
            state_d = illegal ? DONE : LOAD_A;
         end
         LOAD_A: begin
            rd_req_o  = 1'b1;
            rd_addr_o = ADDR_WIDTH'({row_q, OP_A});
            if (rd_valid_i) begin
               a_d[row_q] = rd_data_i;
               row_d      = last_row_n ? '0 : row_q + IW'(1);
               if (last_row_n) state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            rd_req_o  = 1'b1;
            rd_addr_o = ADDR_WIDTH'({row_q, OP_B});
            if (rd_valid_i) begin
               b_d[row_q] = rd_data_i;
               row_d      = last_row_k ? '0 : row_q + IW'(1);
`ifdef MATMUL_BIAS_EN
               if (last_row_k) state_d = bias_q ? LOAD_C : CALC;
`else
               if (last_row_k) state_d = CALC;
`endif
            end
         end
`ifdef MATMUL_BIAS_EN
         LOAD_C: begin
            rd_req_o  = 1'b1;
            rd_addr_o = ADDR_WIDTH'({elem, OP_C});
            if (rd_valid_i) begin
               c_d[elem] = rd_data_i;
               if (!last_col) col_d = col_q + IW'(1);
               else begin
                  col_d = '0;
                  row_d = last_row_n ? '0 : row_q + IW'(1);
                  if (last_row_n) state_d = CALC;
               end
            end
         end
`endif
         CALC: begin
            mac_en         = 1'b1;
            mac_load       = (idx_q == '0);
            flags_d[elem]  = flags_q[elem] | mac_ovf;
            idx_d          = last_idx ? '0 : idx_q + IW'(1);
            if (last_idx) state_d = WRITE;
         end
         WRITE: begin
            wr_en_o   = 1'b1;
            wr_addr_o = ADDR_WIDTH'({elem, OP_C});
            wr_data_o = mac_acc;
            if (wr_ready_i) begin
               state_d = CALC;
               if (!last_col) col_d = col_q + IW'(1);
               else begin
                  col_d = '0;
                  row_d = last_row_n ? '0 : row_q + IW'(1);
                  if (last_row_n) state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         idx_q   <= '0;
         n_q     <= '0;
         k_q     <= '0;
         m_q     <= '0;
         err_q   <= 1'b0;
         flags_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         k_q     <= k_d;
         m_q     <= m_d;
         err_q   <= err_d;
         flags_q <= flags_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

`ifdef MATMUL_BIAS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bias_q <= 1'b0;
         c_q    <= '0;
      end else begin
         bias_q <= bias_d;
         c_q    <= c_d;
      end
   end
`endif

   assign busy_o  = (state_q != IDLE) && (state_q != DONE);
   assign done_o  = (state_q == DONE);
   assign err_o   = (state_q == DONE) && err_q;
   assign flags_o = flags_q;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Self-checking bench for matmul_seq_engine (DATA_WIDTH=8, BUS_WIDTH=16, MAX_DIM=2).
module tb_matmul_seq_engine;
   localparam int DW = 8, BW = 16, AW = 32, MD = 2, DIMW = 2, NE = 4;

   logic            clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, mode_i = 1'b0;
   logic [DIMW-1:0] n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
   logic            rd_req_o, wr_en_o, busy_o, done_o, err_o;
   logic [AW-1:0]   rd_addr_o, wr_addr_o;
   logic [BW-1:0]   rd_data_i = '0, wr_data_o;
   logic            rd_valid_i = 1'b0, wr_ready_i = 1'b0;
   logic [NE-1:0]   flags_o;

   int checks = 0, errors = 0;
   bit bias_hw;
   logic signed [DW-1:0] a_m[MD][MD], b_m[MD][MD];
   logic signed [BW-1:0] c_m[NE];
   logic [BW-1:0]        exp_data[NE];
   bit                   exp_ovf[NE];
   logic [BW-1:0]        last_wd, first_wd;

   matmul_seq_engine dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
      .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .flags_o(flags_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer dot products, overflow = any partial sum outside 16-bit signed range.
   task automatic model(input int n, input int k, input int m, input bit use_bias);
      longint acc, s;
      logic signed [BW-1:0] w;
      bit ovf;
      for (int e = 0; e < NE; e++) begin exp_data[e] = '0; exp_ovf[e] = 1'b0; end
      for (int i = 0; i < n; i++)
         for (int j = 0; j < m; j++) begin
            acc = use_bias ? longint'(c_m[i*MD+j]) : 0;
            ovf = 1'b0;
            for (int l = 0; l < k; l++) begin
               s = acc + longint'(a_m[i][l]) * longint'(b_m[l][j]);
               if (s > 32767 || s < -32768) ovf = 1'b1;
               w = s[BW-1:0];
               acc = longint'(w);
            end
            exp_data[i*MD+j] = acc[BW-1:0];
            exp_ovf[i*MD+j]  = ovf;
         end
   endtask

   function automatic logic [BW-1:0] spad(input logic [AW-1:0] addr);
      logic [BW-1:0] w;
      int idx;
      w   = 16'hDEAD;
      idx = int'(addr[6:5]);
      case (addr[4:0])
         5'b00100: if (idx < MD) for (int l = 0; l < MD; l++) w[l*DW +: DW] = a_m[idx][l];
         5'b01000: if (idx < MD) for (int l = 0; l < MD; l++) w[l*DW +: DW] = b_m[idx][l];
         5'b10000: w = c_m[idx];
         default:  w = 16'hDEAD;
      endcase
      return w;
   endfunction

   task automatic clear_mats();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin a_m[i][j] = '0; b_m[i][j] = '0; end
      for (int e = 0; e < NE; e++) c_m[e] = '0;
   endtask

   task automatic run_op(input string name, input int n, input int k, input int m,
                         input bit mode, input bit stall);
      int cyc, reads, wi, exp_reads, exp_lat, e;
      bit got_done, use_bias, legal, rd_pend, wr_pend;
      logic [AW-1:0] pa, pwa;
      logic [BW-1:0] pwd;
      logic [NE-1:0] ef;
      legal     = n >= 1 && n <= MD && k >= 1 && k <= MD && m >= 1 && m <= MD;
      use_bias  = bias_hw && mode && legal;
      model(legal ? n : 0, k, m, use_bias);
      ef = '0;
      for (int x = 0; x < NE; x++) ef[x] = exp_ovf[x];
      exp_reads = legal ? n + k + (use_bias ? n*m : 0) : 0;
      exp_lat   = legal ? 1 + n + k + (use_bias ? n*m : 0) + n*m*(k+1) : 1;
      cyc = 0; reads = 0; wi = 0; got_done = 0; rd_pend = 0; wr_pend = 0;
      pa = '0; pwa = '0; pwd = '0;
      @(negedge clk_i);
      start_i = 1'b1; mode_i = mode;
      n_dim_i = DIMW'(n); k_dim_i = DIMW'(k); m_dim_i = DIMW'(m);
      rd_valid_i = 1'b0; wr_ready_i = 1'b0;
      @(posedge clk_i);
      while (!got_done && cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         start_i = 1'b0;
         if (cyc == 3 && !done_o) begin
            start_i = 1'b1; mode_i = ~mode;
            n_dim_i = DIMW'($urandom_range(0, 3)); k_dim_i = DIMW'($urandom_range(0, 3));
            m_dim_i = DIMW'($urandom_range(0, 3));
         end
         if (cyc == 1) check({name, " busy"}, busy_o, legal);
         if (rd_pend) check({name, " rd hold"}, {rd_req_o, rd_addr_o}, {1'b1, pa});
         if (wr_pend) check({name, " wr hold"}, {wr_en_o, wr_addr_o, wr_data_o}, {1'b1, pwa, pwd});
         if (done_o) begin
            got_done = 1;
            if (stall) check({name, " latency min"}, cyc >= exp_lat, 1'b1);
            else       check({name, " latency"}, cyc, exp_lat);
            check({name, " busy at done"}, busy_o, 1'b0);
            check({name, " err"}, err_o, !legal);
            check({name, " flags"}, flags_o, ef);
            check({name, " reads"}, reads, exp_reads);
            check({name, " writes"}, wi, legal ? n*m : 0);
         end else begin
            rd_valid_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            rd_data_i  = spad(rd_addr_o);
            rd_pend = rd_req_o && !rd_valid_i; pa = rd_addr_o;
            wr_pend = wr_en_o && !wr_ready_i; pwa = wr_addr_o; pwd = wr_data_o;
            if (rd_req_o && rd_valid_i) reads++;
            if (wr_en_o && wr_ready_i) begin
               if (wi < n*m) begin
                  e = (wi / m) * MD + (wi % m);
                  check({name, " wr addr"}, wr_addr_o, AW'(e*32 + 16));
                  check({name, " wr data"}, wr_data_o, exp_data[e]);
               end
               if (wi == 0) first_wd = wr_data_o;
               last_wd = wr_data_o;
               wi++;
            end
         end
      end
      if (!got_done) check({name, " timeout"}, got_done, 1'b1);
      rd_valid_i = 1'b0; wr_ready_i = 1'b0; start_i = 1'b0;
      @(negedge clk_i);
      check({name, " done pulse"}, {done_o, busy_o}, 2'b00);
      check({name, " flags hold"}, flags_o, ef);
   endtask

   initial begin
      logic [BW-1:0] want;
      bit any_done, any_wr;
`ifdef MATMUL_BIAS_EN
      bias_hw = 1'b1;
`else
      bias_hw = 1'b0;
`endif
      clear_mats();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset outputs", {rd_req_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
                              busy_o, done_o, err_o, flags_o}, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("idle outputs", {rd_req_o, wr_en_o, busy_o, done_o, err_o, flags_o}, '0);

      // A = I, B = [[1,2],[3,4]]
      clear_mats();
      a_m[0][0] = 1; a_m[1][1] = 1;
      b_m[0][0] = 1; b_m[0][1] = 2; b_m[1][0] = 3; b_m[1][1] = 4;
      run_op("identity", 2, 2, 2, 1'b0, 1'b0);
      check("identity last", last_wd, 16'd4);

      // A = [[1,2],[4,5]], B = [7,8]^T -> 23, 68
      clear_mats();
      a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 4; a_m[1][1] = 5;
      b_m[0][0] = 7; b_m[1][0] = 8;
      run_op("rect", 2, 2, 1, 1'b0, 1'b0);
      check("rect first", first_wd, 16'd23);
      check("rect last", last_wd, 16'd68);
      run_op("rect stall", 2, 2, 1, 1'b0, 1'b1);
      check("rect stall last", last_wd, 16'd68);

      clear_mats();
      a_m[0][0] = 3; b_m[0][0] = -4; c_m[0] = 100;
      run_op("bias", 1, 1, 1, 1'b1, 1'b0);
      want = bias_hw ? 16'd88 : 16'hFFF4;
      check("bias value", last_wd, want);

      clear_mats();
      a_m[0][0] = -128; a_m[0][1] = -128; b_m[0][0] = -128; b_m[1][0] = -128;
      run_op("overflow", 1, 2, 1, 1'b0, 1'b0);
      check("overflow value", last_wd, 16'h8000);
      check("overflow flag", flags_o[0], 1'b1);

      run_op("k zero", 1, 0, 1, 1'b0, 1'b0);
      run_op("n three", 3, 1, 1, 1'b0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < MD; i++)
            for (int j = 0; j < MD; j++) begin
               a_m[i][j] = (t % 3 == 0) ? DW'($urandom_range(0, 1) ? 8'h80 : 8'h7F) : DW'($urandom);
               b_m[i][j] = DW'($urandom);
            end
         for (int e = 0; e < NE; e++) c_m[e] = BW'($urandom);
         run_op("random", $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2),
                1'($urandom_range(0, 1)), t[0]);
      end

      // Abort mid-CALC with an asynchronous reset.
      @(negedge clk_i);
      start_i = 1'b1; mode_i = 1'b0; n_dim_i = 2; k_dim_i = 2; m_dim_i = 2;
      rd_valid_i = 1'b1; wr_ready_i = 1'b1;
      @(posedge clk_i);
      repeat (6) begin
         @(negedge clk_i);
         start_i = 1'b0;
         rd_data_i = spad(rd_addr_o);
      end
      check("pre-reset busy", busy_o, 1'b1);
      rst_ni = 1'b0;
      #1;
      check("async reset outputs", {rd_req_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
                                    busy_o, done_o, err_o, flags_o}, '0);
      @(posedge clk_i); #1;
      check("reset edge outputs", {rd_req_o, wr_en_o, busy_o, done_o, err_o, flags_o}, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      any_done = 0; any_wr = 0;
      repeat (10) begin
         @(negedge clk_i);
         any_done |= done_o;
         any_wr   |= wr_en_o;
      end
      check("no done after abort", {any_done, any_wr}, 2'b00);
      rd_valid_i = 1'b0; wr_ready_i = 1'b0;
      run_op("after reset", 2, 1, 2, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
